// File: rtl/avalon_mm_pkg.sv
// Shared definitions for the Avalon-MM master and the memory-mapped peripherals.
// Holds the master FSM encoding, response error codes and a counter-width helper.
package avalon_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_LAT  = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic RSP_OK          = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    // Bits needed to count up to max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM master: one valid/ready command becomes one bus
// cycle and one response, with waitrequest stalls, fixed read latency and timeout.
module avalon_mm_master
    import avalon_mm_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W/8-1:0] cmd_byteenable,
    input  logic [DATA_W-1:0]   cmd_writedata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int WAIT_W = cnt_w(TIMEOUT);
    localparam int LAT_W  = cnt_w(READ_LATENCY);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0]  LAT_C     = LAT_W'(READ_LATENCY);

    state_e                r_state;
    state_e                w_next_state;
    logic                  r_write;
    logic [ADDR_W-1:0]     r_address;
    logic [DATA_W/8-1:0]   r_byteenable;
    logic [DATA_W-1:0]     r_writedata;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_rsp_error;

    logic w_take_cmd;
    logic w_accept;
    logic w_timeout;
    logic w_lat_done;

    assign w_take_cmd = (r_state == ST_IDLE) && cmd_valid;
    assign w_accept   = (r_state == ST_BUS) && !avm_waitrequest;
    // Acceptance outranks timeout because w_timeout requires waitrequest still high.
    assign w_timeout  = (TIMEOUT != 0) && (r_state == ST_BUS) && avm_waitrequest
                        && (r_wait_cnt == TIMEOUT_C);
    assign w_lat_done = (r_state == ST_LAT) && (r_lat_cnt == LAT_C);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_next_state = ST_BUS;
                else           w_next_state = ST_IDLE;
            end
            ST_BUS: begin
                if (w_accept) begin
                    if (r_write || (READ_LATENCY == 0)) w_next_state = ST_RSP;
                    else                                w_next_state = ST_LAT;
                end else if (w_timeout) begin
                    w_next_state = ST_RSP;
                end else begin
                    w_next_state = ST_BUS;
                end
            end
            ST_LAT: begin
                if (w_lat_done) w_next_state = ST_RSP;
                else            w_next_state = ST_LAT;
            end
            ST_RSP: begin
                if (rsp_ready) w_next_state = ST_IDLE;
                else           w_next_state = ST_RSP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Command latch, wait/latency counters and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_address    <= '0;
            r_byteenable <= '0;
            r_writedata  <= '0;
            r_wait_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= RSP_OK;
        end else begin
            if (w_take_cmd) begin
                r_write      <= cmd_write;
                r_address    <= cmd_address;
                r_byteenable <= cmd_byteenable;
                r_writedata  <= cmd_writedata;
                r_wait_cnt   <= '0;
            end else if ((r_state == ST_BUS) && avm_waitrequest) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (w_accept) begin
                r_lat_cnt <= LAT_W'(1);
            end else if (r_state == ST_LAT) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end

            if (w_accept) begin
                r_rsp_error <= RSP_OK;
                if (!r_write && (READ_LATENCY == 0)) r_rsp_data <= avm_readdata;
                else                                 r_rsp_data <= '0;
            end else if (w_timeout) begin
                r_rsp_error <= RSP_ERR_TIMEOUT;
                r_rsp_data  <= '0;
            end else if (w_lat_done) begin
                r_rsp_error <= RSP_OK;
                r_rsp_data  <= avm_readdata;
            end
        end
    end

    // Outputs decoded from registered state; strobes fall with the async reset
    always_comb begin
        cmd_ready      = (r_state == ST_IDLE);
        rsp_valid      = (r_state == ST_RSP);
        rsp_data       = r_rsp_data;
        rsp_error      = r_rsp_error;
        avm_read       = (r_state == ST_BUS) && !r_write;
        avm_write      = (r_state == ST_BUS) && r_write;
        avm_chipselect = (r_state == ST_BUS);
        avm_address    = r_address;
        avm_byteenable = r_byteenable;
        avm_writedata  = r_writedata;
    end

endmodule

// File: tb/tb_avalon_mm_master.sv
// Bench for avalon_mm_master: three instances (different latency/timeout) share
// stimulus; a transaction-level model predicts strobe windows and responses.
module tb_avalon_mm_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int RL_0 = 0, TO_0 = 255;
    localparam int RL_1 = 2, TO_1 = 0;
    localparam int RL_2 = 0, TO_2 = 4;

    logic          clk = 1'b0;
    logic          reset;
    int            sel;
    logic          cmd_valid, cmd_write, rsp_ready, avm_waitrequest;
    logic [AW-1:0] cmd_address;
    logic [BW-1:0] cmd_byteenable;
    logic [DW-1:0] cmd_writedata, avm_readdata;

    logic          cr_0, cr_1, cr_2, rv_0, rv_1, rv_2, re_0, re_1, re_2;
    logic [DW-1:0] rd_0, rd_1, rd_2, wd_0, wd_1, wd_2;
    logic [AW-1:0] ad_0, ad_1, ad_2;
    logic [BW-1:0] be_0, be_1, be_2;
    logic          cs_0, cs_1, cs_2, r_0, r_1, r_2, w_0, w_1, w_2;

    logic          cmd_ready, rsp_valid, rsp_error, avm_chipselect, avm_read, avm_write;
    logic [DW-1:0] rsp_data, avm_writedata;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_byteenable;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_mm_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL_0), .TIMEOUT(TO_0)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && (sel == 0)), .cmd_ready(cr_0),
        .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_byteenable(cmd_byteenable),
        .cmd_writedata(cmd_writedata), .rsp_valid(rv_0), .rsp_ready(rsp_ready),
        .rsp_data(rd_0), .rsp_error(re_0), .avm_address(ad_0), .avm_byteenable(be_0),
        .avm_chipselect(cs_0), .avm_read(r_0), .avm_write(w_0), .avm_writedata(wd_0),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

    avalon_mm_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL_1), .TIMEOUT(TO_1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && (sel == 1)), .cmd_ready(cr_1),
        .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_byteenable(cmd_byteenable),
        .cmd_writedata(cmd_writedata), .rsp_valid(rv_1), .rsp_ready(rsp_ready),
        .rsp_data(rd_1), .rsp_error(re_1), .avm_address(ad_1), .avm_byteenable(be_1),
        .avm_chipselect(cs_1), .avm_read(r_1), .avm_write(w_1), .avm_writedata(wd_1),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

    avalon_mm_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL_2), .TIMEOUT(TO_2)) u_dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && (sel == 2)), .cmd_ready(cr_2),
        .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_byteenable(cmd_byteenable),
        .cmd_writedata(cmd_writedata), .rsp_valid(rv_2), .rsp_ready(rsp_ready),
        .rsp_data(rd_2), .rsp_error(re_2), .avm_address(ad_2), .avm_byteenable(be_2),
        .avm_chipselect(cs_2), .avm_read(r_2), .avm_write(w_2), .avm_writedata(wd_2),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

    // Present the selected instance's outputs on common names
    always_comb begin
        case (sel)
            1: begin
                cmd_ready = cr_1; rsp_valid = rv_1; rsp_data = rd_1; rsp_error = re_1;
                avm_address = ad_1; avm_byteenable = be_1; avm_chipselect = cs_1;
                avm_read = r_1; avm_write = w_1; avm_writedata = wd_1;
            end
            2: begin
                cmd_ready = cr_2; rsp_valid = rv_2; rsp_data = rd_2; rsp_error = re_2;
                avm_address = ad_2; avm_byteenable = be_2; avm_chipselect = cs_2;
                avm_read = r_2; avm_write = w_2; avm_writedata = wd_2;
            end
            default: begin
                cmd_ready = cr_0; rsp_valid = rv_0; rsp_data = rd_0; rsp_error = re_0;
                avm_address = ad_0; avm_byteenable = be_0; avm_chipselect = cs_0;
                avm_read = r_0; avm_write = w_0; avm_writedata = wd_0;
            end
        endcase
    end

    function automatic int rl_of(input int s);
        case (s)
            1:       return RL_1;
            2:       return RL_2;
            default: return RL_0;
        endcase
    endfunction

    function automatic int to_of(input int s);
        case (s)
            1:       return TO_1;
            2:       return TO_2;
            default: return TO_0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One command on instance s. waits = waitrequest-high cycles at the start of the
    // bus phase, rdly = cycles rsp_ready is held low, hold_next keeps cmd_valid high in RSP.
    task automatic txn(input int s, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rv, input int waits,
                       input int rdly, input bit hold_next);
        int rl, to, bus_n, rsp_k;
        bit tmo, strobe;
        logic [DW-1:0] exp_data;
        rl = rl_of(s);
        to = to_of(s);
        tmo = (to != 0) && (waits > to);
        bus_n = tmo ? to + 1 : waits + 1;
        rsp_k = tmo ? to + 2 : waits + 2 + (wr ? 0 : rl);
        exp_data = (wr || tmo) ? '0 : rv;

        @(posedge clk); #1;
        sel = s; cmd_valid = 1'b1; cmd_write = wr; cmd_address = a;
        cmd_byteenable = be; cmd_writedata = wd;
        avm_waitrequest = 1'b0; avm_readdata = ~rv; rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_strobes", {avm_read, avm_write, avm_chipselect}, 0);

        for (int k = 1; k < rsp_k; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_write = ~wr; cmd_address = ~a;
            cmd_byteenable = ~be; cmd_writedata = ~wd;
            avm_waitrequest = (k <= waits);
            avm_readdata = (!wr && (k == 1 + waits + rl)) ? rv : ~rv;
            @(negedge clk);
            strobe = (k <= bus_n);
            chk("bus_read", avm_read, strobe && !wr);
            chk("bus_write", avm_write, strobe && wr);
            chk("bus_cs", avm_chipselect, strobe);
            chk("bus_cmd_ready", cmd_ready, 0);
            chk("bus_rsp_valid", rsp_valid, 0);
            if (strobe) begin
                chk("bus_addr", avm_address, a);
                chk("bus_be", avm_byteenable, be);
                if (wr) chk("bus_wdata", avm_writedata, wd);
            end
        end

        for (int j = 0; j <= rdly; j++) begin
            @(posedge clk); #1;
            avm_waitrequest = 1'b0; avm_readdata = ~rv;
            rsp_ready = (j == rdly);
            cmd_valid = hold_next;
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_error", rsp_error, tmo);
            chk("rsp_cmd_ready", cmd_ready, 0);
            chk("rsp_strobes", {avm_read, avm_write, avm_chipselect}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sel = 0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        cmd_byteenable = '0; cmd_writedata = '0; rsp_ready = 1'b1;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            chk("reset_cmd_ready", cmd_ready, 1);
            chk("reset_rsp", {rsp_valid, rsp_error, rsp_data}, 0);
            chk("reset_bus", {avm_read, avm_write, avm_chipselect, avm_address,
                              avm_byteenable, avm_writedata}, 0);
        end

        txn(0, 1'b1, 16'd3, 4'hF, 32'h0000_00FF, 32'h0, 0, 0, 1'b0);
        txn(0, 1'b0, 16'h0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        txn(1, 1'b0, 16'h0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        txn(0, 1'b0, 16'h0123, 4'h3, 32'h0, 32'hCAFE_F00D, 5, 0, 1'b0);
        txn(2, 1'b0, 16'h0044, 4'hC, 32'h0, 32'h1234_5678, 100, 0, 1'b0);
        txn(2, 1'b1, 16'h0045, 4'h5, 32'hA5A5_5A5A, 32'h0, 100, 0, 1'b0);
        txn(2, 1'b0, 16'h0046, 4'hF, 32'h0, 32'h8765_4321, 4, 0, 1'b0);
        txn(0, 1'b0, 16'h0200, 4'hF, 32'h0, 32'h0BAD_CAFE, 1, 10, 1'b1);
        txn(0, 1'b1, 16'h0201, 4'h1, 32'h1111_2222, 32'h0, 0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom),
                $urandom, $urandom, $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
        end

        // Async reset while stalled in the bus phase
        @(posedge clk); #1;
        sel = 0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0055;
        avm_waitrequest = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("prereset_read", avm_read, 1);
        #2 reset = 1'b1;
        #1;
        chk("reset_strobes_async", {avm_read, avm_write, avm_chipselect}, 0);
        @(negedge clk) reset = 1'b0;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("postreset_cmd_ready", cmd_ready, 1);
            chk("postreset_no_rsp", rsp_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_mm_master.md
# avalon_mm_master

Single-outstanding Avalon-MM master that turns a valid/ready command stream into Avalon read/write bus cycles and returns one response per command. It is the initiator counterpart to the team's memory-mapped peripherals (GPIO, UART) and is used by on-fabric sequencers and test logic to drive those registers without the HPS. It supports `waitrequest` stalls, a fixed read latency, and a bus timeout that produces an error response.

## Interface
- ADDR_W, 16, address width, passed through in the slave's addressing units
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 0, cycles from read acceptance to valid `avm_readdata` (0 = same cycle)
- TIMEOUT, 255, max waitrequest-high cycles before abort; 0 disables the timeout
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target address
- cmd_byteenable  in  DATA_W/8  byte lanes
- cmd_writedata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  DATA_W  read data; 0 for writes and errors
- rsp_error  out  1  1 = timeout abort
- avm_address  out  ADDR_W  bus address
- avm_byteenable  out  DATA_W/8  bus byte lanes
- avm_chipselect  out  1  high whenever avm_read or avm_write is high
- avm_read  out  1  bus read strobe
- avm_write  out  1  bus write strobe
- avm_writedata  out  DATA_W  bus write data
- avm_readdata  in  DATA_W  bus read data
- avm_waitrequest  in  1  slave stall

## Operation
- FSM states: IDLE, BUS, LAT, RSP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid, register write/address/byteenable/writedata and go to BUS. No other state accepts commands.
- BUS: drive registered avm_* from the latched command. The transfer is accepted at the first edge with avm_waitrequest=0.
  - Write accepted: go to RSP with rsp_data=0, rsp_error=0.
  - Read accepted, READ_LATENCY=0: capture avm_readdata at that edge and go to RSP.
  - Read accepted, READ_LATENCY>0: go to LAT with lat_cnt=1.
  - The wait counter increments on every edge with waitrequest=1. When the counter equals TIMEOUT with waitrequest still 1 (and TIMEOUT≠0), go to RSP with rsp_error=1 and rsp_data=0. Acceptance in that same cycle takes priority over the timeout.
- LAT: strobes low. lat_cnt increments each cycle. When lat_cnt==READ_LATENCY, capture avm_readdata and go to RSP.
- RSP: rsp_valid=1 with stable data and error until rsp_ready. On the rsp_ready edge go to IDLE. A held rsp_ready completes in one cycle.
- Outside BUS, avm_read, avm_write and avm_chipselect are 0. avm_address, avm_byteenable and avm_writedata hold their last values.
- Wait counter width is clog2(TIMEOUT+1), minimum 1. It clears on entry to BUS. lat_cnt width is clog2(READ_LATENCY+1).

## Timing
- Reset values: cmd_ready=1 (IDLE); every other output is 0.
- Command accepted at edge t. Strobe is high in cycle t+1.
- Zero-wait write: rsp_valid in cycle t+2.
- Zero-wait read: rsp_valid in cycle t+2+READ_LATENCY.
- Each waitrequest cycle adds one cycle.
- Minimum command-to-command spacing is 3 cycles (IDLE, BUS, RSP).
- Timeout: the strobe stays high for exactly TIMEOUT+1 cycles, then rsp_valid is asserted the next cycle.
- Reset asserted mid-operation: the FSM goes to IDLE immediately. Strobes drop asynchronously. The pending command is discarded and no response is produced.
- rsp_ready held low: the FSM stalls in RSP indefinitely and cmd_ready stays 0 (no back-pressure loss).

## Structure
- Shared package `avalon_mm_pkg` holds the state enum (IDLE/BUS/LAT/RSP) and the response error code constant. The peripherals can reuse it.
- Single module; no sub-module. The wait and latency counters are small enough to live inline.

## Test plan
- Zero-wait write: cmd write addr 3, data 0x0000_00FF, be 0xF. Expect avm_write and avm_chipselect high for 1 cycle with matching bus fields, then rsp_valid with rsp_data=0, rsp_error=0 at t+2.
- Read, READ_LATENCY=0: slave returns 0xDEAD_BEEF combinationally. Expect rsp_data=0xDEAD_BEEF at t+2. Repeat with READ_LATENCY=2: expect rsp_data at t+4 and strobe low during LAT.
- Waitrequest: held 5 cycles on a read. Expect avm_read high for 6 cycles and the response at t+7. Expect address and byteenable stable throughout.
- Timeout, TIMEOUT=4: waitrequest stuck high. Expect the strobe high for 5 cycles, then rsp_error=1 and rsp_data=0. Also drop waitrequest in the 5th strobe cycle: expect a normal response (acceptance wins).
- Back-pressure: rsp_ready low for 10 cycles with a second command waiting. Expect rsp_valid and data stable and cmd_ready=0 until the handshake, then the second command is accepted in the following IDLE cycle.
- Async reset asserted in BUS with waitrequest high. Expect strobes 0 immediately, cmd_ready=1 after release, and no rsp_valid.
